digest_reader: RTL and testbench
================================

DIGEST_READER -- requirements
Module: digest_reader

Interface
REQ-001 SHALL have no parameters; word count (8) and word width (32) are fixed.
REQ-002 clk  input  1  sole clock, all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 done  input  1  single-cycle strobe: final hash-state accumulation complete, digest stable.
REQ-005 digest  input  256  concatenated H1..H8 accumulator outputs; H1 in [255:224], H8 in [31:0].
REQ-006 clr_ovr  input  1  synchronous clear of overrun flag.
REQ-007 out_ready  input  1  downstream accepts out_word this cycle.
REQ-008 out_valid  output  1  out_word holds a valid digest word.
REQ-009 out_word  output  32  current digest word.
REQ-010 out_idx  output  3  index of out_word, 0 = H1 ... 7 = H8.
REQ-011 out_last  output  1  high with out_valid when out_idx == 7.
REQ-012 busy  output  1  high while a digest is held or being streamed.
REQ-013 overrun  output  1  sticky: done arrived while busy and was dropped.

Function
REQ-014 SHALL implement FSM states IDLE and SEND; IDLE on reset.
REQ-015 IDLE, done=1 -> capture all 256 digest bits into internal buffer, idx=0, go SEND; out_valid high next cycle (latency 1).
REQ-016 SEND: out_valid=1, out_word = buffered word[idx], busy=1.
REQ-017 Handshake = out_valid && out_ready; only a handshake advances idx by 1.
REQ-018 out_word, out_idx, out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 Handshake at idx=7 with done=0 -> IDLE; out_valid, busy low next cycle; idx wraps to 0.
REQ-020 Handshake at idx=7 with done=1 in same cycle -> capture new digest, idx=0, stay SEND; out_valid stays high, no gap.
REQ-021 done=1 in SEND without idx-7 handshake -> digest ignored, buffer untouched, overrun set next cycle.
REQ-022 overrun clears on clr_ovr=1; if clr_ovr and a new overrun event coincide, overrun stays set.
REQ-023 done in IDLE never sets overrun.
REQ-024 out_ready while out_valid=0 SHALL have no effect.
REQ-025 Buffer SHALL be captured only at REQ-015/REQ-020 events; digest changes otherwise ignored.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, out_valid=0, busy=0, overrun=0, out_idx=0, out_last=0, out_word=32'h0, buffer all zero.
REQ-027 Reset mid-stream SHALL abandon the remaining words; no word re-emitted after rst_n deasserts until a new done.
REQ-028 First done accepted on the first rising edge with rst_n=1.

Configuration
REQ-029 Macro DIGEST_READER_BSWAP_EN defined: out_word SHALL be byte-reversed buffered word (bits [7:0] to [31:24], etc.) for mining-header little-endian order; capture, indices, timing unchanged.
REQ-030 Macro undefined: out_word SHALL equal buffered word unmodified (big-endian SHA-256 order).

Verification
REQ-031 Reset, digest = SHA-256("abc") (ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad), done pulse, out_ready=1 -> 8 consecutive cycles out_word ba7816bf..f20015ad, out_idx 0..7, out_last only on f20015ad, then out_valid=0.
REQ-032 Same digest, out_ready toggling 1,0,0,1,... -> word/idx held during stalls, exactly 8 handshakes, order unchanged.
REQ-033 done pulsed at idx=3 with different digest -> stream completes with original words, overrun=1; clr_ovr pulse -> overrun=0.
REQ-034 done coincident with idx-7 handshake, second digest all 32'h11111111 -> next cycle out_valid=1, out_idx=0, out_word=11111111, overrun=0.
REQ-035 rst_n low at idx=5 -> out_valid, busy 0 immediately; after release no output until next done, which restarts at idx=0.
REQ-036 With DIGEST_READER_BSWAP_EN, REQ-031 stimulus -> first word bf1678ba, last word ad1500f2.

Source files
------------

// File: rtl/digest_reader_if.sv
// Bundle of the digest capture inputs and word-stream outputs of digest_reader.
// The slave modport is the reader itself; the master modport is whoever drives it.
interface digest_reader_if;
    logic         done;
    logic [255:0] digest;
    logic         clr_ovr;
    logic         out_ready;
    logic         out_valid;
    logic [31:0]  out_word;
    logic [2:0]   out_idx;
    logic         out_last;
    logic         busy;
    logic         overrun;

    modport slave (
        input  done, digest, clr_ovr, out_ready,
        output out_valid, out_word, out_idx, out_last, busy, overrun
    );

    modport master (
        output done, digest, clr_ovr, out_ready,
        input  out_valid, out_word, out_idx, out_last, busy, overrun
    );
endinterface

// File: rtl/digest_reader.sv
// Captures a 256-bit SHA-256 digest on done and streams it as eight 32-bit words (H1 first).
// Define DIGEST_READER_BSWAP_EN to byte-reverse each emitted word (little-endian header order).
module digest_reader (
    input  logic             clk,
    input  logic             rst_n,
    digest_reader_if.slave   bus
);
    typedef enum logic {StIdle, StSend} state_e;

    state_e       state_q, state_d;
    logic [2:0]   idx_q, idx_d;
    logic [255:0] buf_q, buf_d;
    logic         ovr_q, ovr_d;
    logic         valid;
    logic         hs;
    logic         last_hs;
    logic [31:0]  word;

    assign valid   = (state_q == StSend);
    assign hs      = valid && bus.out_ready;
    assign last_hs = hs && (idx_q == 3'd7);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        ovr_d   = ovr_q;
        unique case (state_q)
            StIdle: begin
                if (bus.done) begin
                    buf_d   = bus.digest;
                    idx_d   = 3'd0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (last_hs) begin
                    idx_d = 3'd0;
                    // A done landing on the final handshake chains straight into the next digest.
                    if (bus.done) begin
                        buf_d = bus.digest;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (hs) begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Set wins over clear so a coincident overrun is never lost.
        if (valid && bus.done && !last_hs) begin
            ovr_d = 1'b1;
        end else if (bus.clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
            buf_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            ovr_q   <= ovr_d;
        end
    end

    // H1 sits in the top word, so index 0 selects bits [255:224].
    assign word = buf_q[{~idx_q, 5'b00000} +: 32];

`ifdef DIGEST_READER_BSWAP_EN
    assign bus.out_word = {word[7:0], word[15:8], word[23:16], word[31:24]};
`else
    assign bus.out_word = word;
`endif

    assign bus.out_valid = valid;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = valid && (idx_q == 3'd7);
    assign bus.busy      = valid;
    assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_digest_reader.sv
// Scoreboard bench for digest_reader: stimulus pushes expected words, a negedge monitor
// pops and compares on every handshake.
module tb_digest_reader;
    logic clk;
    logic rst_n;

    digest_reader_if dif ();

    digest_reader u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] word;
        logic [2:0]  idx;
        logic        last;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          hs_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_word;
    logic [2:0]  prev_idx;

    localparam logic [255:0] AbcDigest = {
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
    };
    localparam logic [255:0] OnesDigest = {8{32'h11111111}};
    localparam logic [255:0] OtherDigest = {8{32'hdeadbeef}};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef DIGEST_READER_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic push_digest(input logic [255:0] d);
        logic [255:0] tmp;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            tmp    = d >> (32 * (7 - i));
            e.word = exp_word(tmp[31:0]);
            e.idx  = 3'(i);
            e.last = (i == 7);
            sb_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input logic [2:0] n);
        for (int k = 0; k < 100; k++) begin
            if (dif.out_valid && dif.out_idx == n) break;
            tick();
        end
        check("wait_idx", {28'd0, dif.out_valid, dif.out_idx}, {28'd0, 1'b1, n});
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100; k++) begin
            if (!dif.out_valid) break;
            tick();
        end
        check("idle_valid", 32'(dif.out_valid), 32'd0);
        check("idle_busy", 32'(dif.busy), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic pulse_done(input logic [255:0] d);
        dif.digest = d;
        dif.done   = 1'b1;
        tick();
        dif.done   = 1'b0;
    endtask

    // Monitor: every handshake must match the head of the scoreboard; stalls must hold.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && dif.out_valid) begin
                check("stall_word", dif.out_word, prev_word);
                check("stall_idx", 32'(dif.out_idx), 32'(prev_idx));
            end
            if (dif.out_valid && dif.out_ready) begin
                hs_cnt++;
                if (sb_q.size() == 0) begin
                    check("unexpected_word", dif.out_word, 32'hxxxxxxxx);
                end else begin
                    e = sb_q.pop_front();
                    check("word", dif.out_word, e.word);
                    check("idx", 32'(dif.out_idx), 32'(e.idx));
                    check("last", 32'(dif.out_last), 32'(e.last));
                end
            end
            prev_stall <= dif.out_valid && !dif.out_ready;
            prev_word  <= dif.out_word;
            prev_idx   <= dif.out_idx;
        end
    end

    initial begin
        int hs0;
        rst_n         = 1'b0;
        dif.done      = 1'b0;
        dif.digest    = '0;
        dif.clr_ovr   = 1'b0;
        dif.out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(dif.out_valid), 32'd0);
        check("rst_busy", 32'(dif.busy), 32'd0);
        check("rst_ovr", 32'(dif.overrun), 32'd0);
        check("rst_word", dif.out_word, 32'd0);
        check("rst_idx", 32'(dif.out_idx), 32'd0);
        check("rst_last", 32'(dif.out_last), 32'd0);

        // abc digest, done on the first edge after reset release, always ready.
        rst_n         = 1'b1;
        dif.out_ready = 1'b1;
        push_digest(AbcDigest);
        pulse_done(AbcDigest);
        for (int i = 0; i < 8; i++) begin
            check("burst_valid", 32'(dif.out_valid), 32'd1);
            tick();
        end
        check("burst_end_valid", 32'(dif.out_valid), 32'd0);
        wait_idle();

        // Ready pattern 1,0,0 repeating: words held across stalls, exactly 8 handshakes.
        hs0           = hs_cnt;
        dif.out_ready = 1'b0;
        push_digest(AbcDigest);
        pulse_done(AbcDigest);
        for (int k = 0; k < 64; k++) begin
            if (!dif.out_valid) break;
            dif.out_ready = (k % 3 == 0);
            tick();
        end
        wait_idle();
        check("stall_hs_count", 32'(hs_cnt - hs0), 32'd8);

        // done mid-stream is dropped and flags overrun; clr_ovr clears it.
        dif.out_ready = 1'b1;
        push_digest(AbcDigest);
        pulse_done(AbcDigest);
        wait_idx(3'd3);
        pulse_done(OtherDigest);
        check("ovr_set", 32'(dif.overrun), 32'd1);
        wait_idle();
        check("ovr_sticky", 32'(dif.overrun), 32'd1);
        dif.clr_ovr = 1'b1;
        tick();
        dif.clr_ovr = 1'b0;
        check("ovr_clr", 32'(dif.overrun), 32'd0);

        // clr_ovr coincident with a new overrun event: set wins.
        push_digest(AbcDigest);
        pulse_done(AbcDigest);
        wait_idx(3'd2);
        dif.clr_ovr = 1'b1;
        pulse_done(OtherDigest);
        dif.clr_ovr = 1'b0;
        check("ovr_set_wins", 32'(dif.overrun), 32'd1);
        wait_idle();
        dif.clr_ovr = 1'b1;
        tick();
        dif.clr_ovr = 1'b0;

        // done on the idx-7 handshake chains the next digest with no gap.
        push_digest(AbcDigest);
        pulse_done(AbcDigest);
        wait_idx(3'd7);
        push_digest(OnesDigest);
        pulse_done(OnesDigest);
        check("chain_valid", 32'(dif.out_valid), 32'd1);
        check("chain_idx", 32'(dif.out_idx), 32'd0);
        check("chain_word", dif.out_word, exp_word(32'h11111111));
        check("chain_ovr", 32'(dif.overrun), 32'd0);
        wait_idle();

        // Reset at idx 5 abandons the stream; nothing is emitted until the next done.
        push_digest(AbcDigest);
        pulse_done(AbcDigest);
        wait_idx(3'd5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(dif.out_valid), 32'd0);
        check("mid_rst_busy", 32'(dif.busy), 32'd0);
        check("mid_rst_word", dif.out_word, 32'd0);
        sb_q.delete();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("post_rst_quiet", 32'(dif.out_valid), 32'd0);
        push_digest(AbcDigest);
        pulse_done(AbcDigest);
        check("restart_idx", 32'(dif.out_idx), 32'd0);
        check("restart_word", dif.out_word, exp_word(32'hba7816bf));
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
